// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared mode/state encodings and Lucas seeds for the sequence checker.
package seq_chk_pkg;
    typedef enum logic [1:0] {MODE_FIB, MODE_LUCAS, MODE_STEP, MODE_USER} mode_e;
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;
    localparam int LUCAS_A = 2;
    localparam int LUCAS_B = 1;
endpackage

// File: rtl/seq_result_checker_if.sv
// seq_result_checker_if: control, observation and result signals of the sequence checker.
interface seq_result_checker_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              clear;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed_a;
    logic [DATA_W-1:0] seed_b;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic              busy;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [IDX_W-1:0]  term_idx;
    logic [DATA_W-1:0] fail_exp;
    logic [DATA_W-1:0] fail_got;
    modport master (
        output start, clear, mode, seed_a, seed_b, obs_valid, obs_data,
        input  busy, pass, fail, timeout, term_idx, fail_exp, fail_got
    );
    modport slave (
        input  start, clear, mode, seed_a, seed_b, obs_valid, obs_data,
        output busy, pass, fail, timeout, term_idx, fail_exp, fail_got
    );
endinterface

// File: rtl/seq_ref_gen.sv
// seq_ref_gen: reference sequence generator (Fibonacci/Lucas/step/user recurrence).
module seq_ref_gen
    import seq_chk_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  mode_e             mode,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    output logic [DATA_W-1:0] exp_a
);
    logic [DATA_W-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic              step_q, step_d;
    // In step mode exp_b holds the constant step instead of the next term.
    always_comb begin
        exp_a_d = exp_a_q;
        exp_b_d = exp_b_q;
        step_d  = step_q;
        if (load) begin
            step_d  = mode == MODE_STEP;
            exp_a_d = mode == MODE_FIB ? '0 : mode == MODE_LUCAS ? DATA_W'(LUCAS_A) : seed_a;
            exp_b_d = mode == MODE_FIB ? DATA_W'(1) : mode == MODE_LUCAS ? DATA_W'(LUCAS_B) :
                      mode == MODE_STEP ? seed_a : seed_b;
        end else if (adv) begin
            exp_a_d = step_q ? exp_a_q + exp_b_q : exp_b_q;
            exp_b_d = step_q ? exp_b_q : exp_a_q + exp_b_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_a_q <= '0;
            exp_b_q <= '0;
            step_q  <= 1'b0;
        end else begin
            exp_a_q <= exp_a_d;
            exp_b_q <= exp_b_d;
            step_q  <= step_d;
        end
    end
    assign exp_a = exp_a_q;
endmodule

// File: rtl/seq_result_checker.sv
// seq_result_checker: compares CPU output strobes against a reference sequence,
// reporting sticky pass/fail, failing term and inter-strobe timeout.
module seq_result_checker
    import seq_chk_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_TERMS      = 13,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = $clog2(NUM_TERMS + 1),
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    seq_result_checker_if.slave  bus
);
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic [DATA_W-1:0] exp_a;
    logic              adv;
    seq_ref_gen #(.DATA_W(DATA_W)) u_gen (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .load   (bus.start),
        .adv    (adv),
        .mode   (mode_e'(bus.mode)),
        .seed_a (bus.seed_a),
        .seed_b (bus.seed_b),
        .exp_a  (exp_a)
    );
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        to_d       = to_q;
        timeout_d  = timeout_q;
        fail_exp_d = fail_exp_q;
        fail_got_d = fail_got_q;
        adv        = 1'b0;
        if (bus.start || bus.clear) begin
            state_d    = bus.start ? RUN : IDLE;
            idx_d      = '0;
            to_d       = '0;
            timeout_d  = 1'b0;
            fail_exp_d = '0;
            fail_got_d = '0;
        end else if (state_q == RUN) begin
            if (bus.obs_valid && bus.obs_data == exp_a) begin
                adv     = 1'b1;
                idx_d   = idx_q + 1'b1;
                to_d    = '0;
                state_d = idx_q == IDX_W'(NUM_TERMS - 1) ? PASS : RUN;
            end else if (bus.obs_valid) begin
                state_d    = FAIL;
                fail_exp_d = exp_a;
                fail_got_d = bus.obs_data;
            end else begin
                to_d = to_q + 1'b1;
                if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = FAIL;
                    timeout_d  = 1'b1;
                    fail_exp_d = exp_a;
                    fail_got_d = '0;
                end
            end
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            to_q       <= '0;
            timeout_q  <= 1'b0;
            fail_exp_q <= '0;
            fail_got_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            to_q       <= to_d;
            timeout_q  <= timeout_d;
            fail_exp_q <= fail_exp_d;
            fail_got_q <= fail_got_d;
        end
    end
    assign bus.busy     = state_q == RUN;
    assign bus.pass     = state_q == PASS;
    assign bus.fail     = state_q == FAIL;
    assign bus.timeout  = timeout_q;
    assign bus.term_idx = idx_q;
    assign bus.fail_exp = fail_exp_q;
    assign bus.fail_got = fail_got_q;
endmodule

// File: tb/tb_seq_result_checker.sv
// tb_seq_result_checker: directed sequences with a result scoreboard for seq_result_checker.
module tb_seq_result_checker;
    localparam int DW = 8;
    localparam int NT = 13;
    localparam int TO = 16;
    localparam int IW = $clog2(NT + 1);

    typedef struct packed {
        logic          p;
        logic          f;
        logic          t;
        logic [IW-1:0] idx;
        logic [DW-1:0] e;
        logic [DW-1:0] g;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    res_t exp_q[$];
    logic prev_res = 1'b0;

    int fib[$]   = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
    int fib_bad[$] = '{0, 1, 1, 2, 3, 6};
    int usr[$]   = '{89, 144, 233, 121, 98, 219, 61, 24, 85, 109, 194, 47, 241};
    int usr_bad[$] = '{89, 144, 233, 122};
    int step[$]  = '{37, 74, 111, 148, 185, 222, 3, 40, 77, 114, 151, 188, 225};
    int lucas[$] = '{2, 1, 3, 4, 7, 11, 18, 29, 47, 76, 123, 199, 66};
    int fib4[$]  = '{0, 1, 1, 2};

    seq_result_checker_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    seq_result_checker #(.DATA_W(DW), .NUM_TERMS(NT), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(bit p, bit f, bit t, int idx, int e, int g);
        res_t r;
        r.p = p; r.f = f; r.t = t;
        r.idx = IW'(idx); r.e = DW'(e); r.g = DW'(g);
        return r;
    endfunction

    function automatic res_t snap();
        return mk(bus.pass, bus.fail, bus.timeout, int'(bus.term_idx),
                  int'(bus.fail_exp), int'(bus.fail_got));
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("p=%0d f=%0d t=%0d idx=%0d exp=%0d got=%0d",
                         r.p, r.f, r.t, r.idx, r.e, r.g);
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // Scoreboard monitor: each new pass/fail result consumes one expectation.
    always @(negedge clk) begin
        logic r;
        res_t e;
        r = bus.pass | bus.fail;
        if (r && !prev_res) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result: unexpected result %s", fmt(snap()));
            end else begin
                e = exp_q.pop_front();
                if (snap() !== e) begin
                    n_fail++;
                    $display("FAIL result: got %s, expected %s", fmt(snap()), fmt(e));
                end
            end
        end
        prev_res = r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(int m, int a, int b, bit ov, int od, bit clr);
        bus.start = 1'b1; bus.clear = clr; bus.mode = 2'(m);
        bus.seed_a = DW'(a); bus.seed_b = DW'(b);
        bus.obs_valid = ov; bus.obs_data = DW'(od);
        tick();
        bus.start = 1'b0; bus.clear = 1'b0; bus.obs_valid = 1'b0;
    endtask

    task automatic feed(int v, int gap);
        bus.obs_valid = 1'b1; bus.obs_data = DW'(v);
        tick();
        bus.obs_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic feed_seq(input int v[$], int gap);
        for (int i = 0; i < v.size(); i++) feed(v[i], i == v.size() - 1 ? 0 : gap);
    endtask

    initial begin
        int guard;
        bus.start = 1'b0; bus.clear = 1'b0; bus.mode = '0;
        bus.seed_a = '0; bus.seed_b = '0; bus.obs_valid = 1'b0; bus.obs_data = '0;
        repeat (2) tick();
        check("reset_state", 32'({bus.busy, snap()}), 32'd0);
        rst = 1'b0;
        tick();

        exp_q.push_back(mk(1, 0, 0, 13, 0, 0));
        start_run(0, 0, 0, 0, 0, 0);
        check("fib_busy", 32'(bus.busy), 32'd1);
        feed_seq(fib, 3);
        check("fib_pass_latency", 32'({bus.pass, bus.fail, bus.term_idx}), 32'({2'b10, 4'd13}));

        exp_q.push_back(mk(0, 1, 0, 5, 5, 6));
        start_run(0, 0, 0, 0, 0, 0);
        feed_seq(fib_bad, 3);
        check("fib_fail_latency", 32'(bus.fail), 32'd1);

        exp_q.push_back(mk(1, 0, 0, 13, 0, 0));
        start_run(3, 89, 144, 0, 0, 0);
        feed_seq(usr, 2);

        exp_q.push_back(mk(0, 1, 0, 3, 121, 122));
        start_run(3, 89, 144, 0, 0, 0);
        feed_seq(usr_bad, 1);

        exp_q.push_back(mk(0, 1, 1, 0, 0, 0));
        start_run(0, 0, 0, 0, 0, 0);
        repeat (TO - 1) tick();
        check("timeout_early", 32'(bus.fail), 32'd0);
        tick();
        check("timeout_exact", 32'({bus.fail, bus.timeout}), 32'd3);

        exp_q.push_back(mk(0, 1, 1, 1, 9, 0));
        start_run(3, 5, 9, 0, 0, 0);
        feed(5, 0);
        repeat (TO - 1) tick();
        check("timeout_term_early", 32'(bus.fail), 32'd0);
        tick();
        check("timeout_term_exact", 32'({bus.fail, bus.timeout}), 32'd3);

        exp_q.push_back(mk(1, 0, 0, 13, 0, 0));
        start_run(2, 37, 0, 1, 0, 0);
        check("start_discards_obs", 32'({bus.busy, bus.term_idx}), 32'({1'b1, 4'd0}));
        feed_seq(step, 1);

        exp_q.push_back(mk(1, 0, 0, 13, 0, 0));
        start_run(1, 0, 0, 1, 0, 0);
        feed_seq(lucas, 0);

        feed(0, 1);
        check("pass_sticky", 32'({bus.pass, bus.fail, bus.term_idx}), 32'({2'b10, 4'd13}));

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear", 32'({bus.busy, snap()}), 32'd0);

        start_run(0, 0, 0, 0, 0, 1);
        check("start_beats_clear", 32'(bus.busy), 32'd1);
        feed_seq(fib4, 1);
        check("mid_run_idx", 32'(bus.term_idx), 32'd4);
        #1 rst = 1'b1;
        #1 check("async_reset", 32'({bus.busy, snap()}), 32'd0);
        #1 rst = 1'b0;
        tick();

        exp_q.push_back(mk(1, 0, 0, 13, 0, 0));
        start_run(0, 0, 0, 0, 0, 0);
        check("restart_idx", 32'({bus.busy, bus.term_idx}), 32'({1'b1, 4'd0}));
        feed_seq(fib, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_result_checker.md
Name: seq_result_checker

Overview:
- Synthesisable on-chip self-test checker inside user_project_wrapper.
- Monitors the simple CPU's output port and compares each emitted value against an internally generated reference sequence: Fibonacci, Lucas, arithmetic step, or user-seeded recurrence.
- Reports pass/fail, the failing term, and a timeout on GPIO/LA.
- Generalises the fixed Fibonacci program check: width, term count, mode and timeout are configurable, and checking happens in hardware rather than in the bench.

Parameters:
DATA_W, 8, width of observed and expected data; all arithmetic is modulo 2^DATA_W
NUM_TERMS, 13, number of terms that must match for pass (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles allowed between consecutive obs_valid pulses while running (>=1)
IDX_W, $clog2(NUM_TERMS+1), width of term index
TO_W, $clog2(TIMEOUT_CYCLES+1), width of timeout counter

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse; (re)starts a check
clear  in  1  single-cycle pulse; returns to IDLE, clears results
mode  in  2  0=Fibonacci, 1=Lucas, 2=step, 3=user recurrence
seed_a  in  DATA_W  term 0 for mode 2/3; step value in mode 2
seed_b  in  DATA_W  term 1 for mode 3
obs_valid  in  1  CPU output strobe, one term per high cycle
obs_data  in  DATA_W  CPU output value
busy  out  1  high in RUN
pass  out  1  sticky; all NUM_TERMS terms matched
fail  out  1  sticky; mismatch or timeout
timeout  out  1  sticky; fail was caused by timeout
term_idx  out  IDX_W  number of terms matched so far
fail_exp  out  DATA_W  expected value at failure
fail_got  out  DATA_W  observed value at failure (0 on timeout)

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE; all outputs 0; internal exp_a, exp_b and timeout counter set to 0.
- States:
  - IDLE: busy=0; waits for start.
  - RUN: busy=1; checking terms.
  - PASS: pass=1, sticky.
  - FAIL: fail=1, sticky.
- Start handling:
  - start in any state: next cycle enters RUN, term_idx=0, timeout counter=0, pass/fail/timeout/fail_* cleared.
  - Seeds are latched from mode/seed_a/seed_b on the start cycle.
  - Seeds per mode:
    - mode 0: exp_a=0, exp_b=1.
    - mode 1: exp_a=2, exp_b=1.
    - mode 2: exp_a=seed_a, step=seed_a; term n = seed_a*(n+1) mod 2^DATA_W.
    - mode 3: exp_a=seed_a, exp_b=seed_b.
  - mode is ignored outside the start cycle.
- RUN, obs_valid=1 and obs_data==exp_a:
  - term_idx++, timeout counter=0.
  - Advance the generator:
    - modes 0/1/3: exp_a<=exp_b, exp_b<=exp_a+exp_b (truncated to DATA_W).
    - mode 2: exp_a<=exp_a+step (truncated).
  - If this was term NUM_TERMS-1, go to PASS next cycle: pass=1, term_idx=NUM_TERMS.
- RUN, obs_valid=1 and obs_data!=exp_a:
  - Go to FAIL next cycle; fail_exp=exp_a, fail_got=obs_data; term_idx holds the failing index.
- RUN, obs_valid=0:
  - Timeout counter increments.
  - When it reaches TIMEOUT_CYCLES, go to FAIL: timeout=1, fail_exp=exp_a, fail_got=0.
  - Timeout fires exactly TIMEOUT_CYCLES cycles after entering RUN or after the last accepted term.
- Ignored inputs: obs_valid in IDLE/PASS/FAIL is ignored; observed values after PASS never alter the result.
- Simultaneous events:
  - start and obs_valid in the same cycle: start wins; the sample is discarded.
  - clear and start in the same cycle: start wins.
  - clear alone: next cycle IDLE with all outputs 0.
- Result latency: 1 cycle from the deciding obs_valid edge to pass/fail.
- Reset mid-RUN: immediate IDLE with all outputs 0; no partial result retained.

Decomposition:
- Shared package seq_chk_pkg holds:
  - mode encodings MODE_FIB, MODE_LUCAS, MODE_STEP, MODE_USER;
  - state encoding IDLE, RUN, PASS, FAIL;
  - Lucas seed constants.
- One natural sub-module, seq_ref_gen: holds exp_a/exp_b/step with load and advance controls, and outputs exp_a.
- The checker FSM and timeout counter live in seq_result_checker.

Test Plan:
- Mode 0, DATA_W=8, NUM_TERMS=13; feed 0,1,1,2,3,5,8,13,21,34,55,89,144 with gaps of 3 cycles -> pass=1 one cycle after the 13th strobe, term_idx=13, fail=0.
- Mode 0, NUM_TERMS=15; feed through 233 then 121 (377 mod 256) -> pass=1 (wrap-around correct). Feeding 377&0x1FF is not applicable; feeding 122 as the last term instead -> fail, fail_exp=121, fail_got=122, term_idx=14.
- Mode 0; feed 0,1,1,2,3,6 -> fail one cycle after the 6th strobe, term_idx=5, fail_exp=5, fail_got=6, timeout=0.
- TIMEOUT_CYCLES=16; start, then no strobes -> fail and timeout=1 exactly 16 cycles after RUN entry, fail_got=0, term_idx=0.
- Mode 2 with seed_a=7, and mode 1 (Lucas 2,1,3,4,7,11); start asserted together with obs_valid=1, obs_data=0 -> sample discarded. Step-mode sequence 7,14,21 is accepted; Lucas sequence passes with NUM_TERMS=6.
- Assert wb_rst_i asynchronously mid-RUN after 4 matched terms (between clock edges) -> busy/pass/fail/term_idx drop to 0 immediately. A new start then restarts from term 0.
